// File: rtl/sram_march_bist.sv
// March C- BIST sequencer for a single-port SRAM: one operation per cycle, 10*DEPTH op cycles + drain + done.
// Read data is compared one cycle after the read is issued; there is no backpressure, A_START is only sampled in IDLE.
module sram_march_bist #(
    parameter int                      P_DATA_WIDTH = 24,
    parameter int                      P_ADDR_WIDTH = 14,
    parameter int                      DEPTH        = 256,
    parameter logic [P_DATA_WIDTH-1:0] P_BACKGROUND = '0
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    A_START,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_CLK,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [2:0]              A_FAIL_ELEM,
    output logic [15:0]             A_ERR_CNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [P_ADDR_WIDTH-1:0] LAST_ADDR = P_ADDR_WIDTH'(DEPTH - 1);
    localparam logic [P_DATA_WIDTH-1:0] D0 = P_BACKGROUND;
    localparam logic [P_DATA_WIDTH-1:0] D1 = ~P_BACKGROUND;

    logic [1:0]              state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                    phase_q, phase_d;
    logic [P_DATA_WIDTH-1:0] exp_q, exp_d;
    logic                    cmp_vld_q, cmp_vld_d;
    logic [P_ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]              cmp_elem_q, cmp_elem_d;
    logic                    fail_q, fail_d;
    logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]              fail_elem_q, fail_elem_d;
    logic [15:0]             err_cnt_q, err_cnt_d;

    logic                    run;
    logic                    down;
    logic                    single;
    logic                    is_read;
    logic                    is_write;
    logic                    last_op;
    logic                    mismatch;
    logic [P_ADDR_WIDTH-1:0] end_addr;
    logic [P_DATA_WIDTH-1:0] wr_dat;
    logic [P_DATA_WIDTH-1:0] rd_exp;

    // M0 and M5 have one operation per address; M1..M4 read (phase 0) then write (phase 1).
    assign run      = (state_q == S_RUN);
    assign down     = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign single   = (elem_q == 3'd0) || (elem_q == 3'd5);
    assign is_read  = run && ((elem_q == 3'd5) || (!single && !phase_q));
    assign is_write = run && !is_read;
    assign last_op  = single || phase_q;
    assign end_addr = down ? '0 : LAST_ADDR;
    assign wr_dat   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? D1 : D0;
    assign rd_exp   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? D1 : D0;
    assign mismatch = cmp_vld_q && (A_DOUT != exp_q);

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        exp_d       = exp_q;
        cmp_vld_d   = 1'b0;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        err_cnt_d   = err_cnt_q;

        if (is_read) begin
            cmp_vld_d  = 1'b1;
            exp_d      = rd_exp;
            cmp_addr_d = addr_q;
            cmp_elem_d = elem_q;
        end

        if (mismatch) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            if (!fail_q) begin
                fail_d      = 1'b1;
                fail_addr_d = cmp_addr_q;
                fail_elem_d = cmp_elem_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (A_START) begin
                    state_d     = S_RUN;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                    err_cnt_d   = 16'd0;
                end
            end
            S_RUN: begin
                if (!last_op) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == end_addr) begin
                        if (elem_q == 3'd5) begin
                            state_d = S_DRAIN;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            // M3 and M4 walk downward, so they start at the top address.
                            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST_ADDR : '0;
                        end
                    end else begin
                        addr_d = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            exp_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            exp_q       <= exp_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Outputs are forced low combinationally so the SRAM port is released in the reset cycle itself.
    assign A_BIST_CLK  = A_CLK;
    assign A_BIST_BM   = '1;
    assign A_BUSY      = !A_RST && (run || (state_q == S_DRAIN));
    assign A_BIST_EN   = A_BUSY;
    assign A_DONE      = !A_RST && (state_q == S_DONE);
    assign A_BIST_MEN  = !A_RST && run;
    assign A_BIST_WEN  = !A_RST && is_write;
    assign A_BIST_REN  = !A_RST && is_read;
    assign A_BIST_ADDR = (!A_RST && run) ? addr_q : '0;
    assign A_BIST_DIN  = (!A_RST && run) ? wr_dat : '0;
    assign A_FAIL      = !A_RST && fail_q;
    assign A_FAIL_ADDR = A_RST ? '0 : fail_addr_q;
    assign A_FAIL_ELEM = A_RST ? 3'd0 : fail_elem_q;
    assign A_ERR_CNT   = A_RST ? 16'd0 : err_cnt_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist with a behavioural SRAM that can plant stuck-at faults.
module tb_sram_march_bist;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] dout;
    logic        en, bclk, men, wen, ren, busy, done, fail;
    logic [13:0] addr, fail_addr;
    logic [23:0] din, bm;
    logic [2:0]  fail_elem;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int fault_mode = 0;

    logic [23:0] mem [0:16383];

    sram_march_bist dut (
        .A_CLK       (clk),
        .A_RST       (rst),
        .A_START     (start),
        .A_DOUT      (dout),
        .A_BIST_EN   (en),
        .A_BIST_CLK  (bclk),
        .A_BIST_ADDR (addr),
        .A_BIST_DIN  (din),
        .A_BIST_BM   (bm),
        .A_BIST_MEN  (men),
        .A_BIST_WEN  (wen),
        .A_BIST_REN  (ren),
        .A_BUSY      (busy),
        .A_DONE      (done),
        .A_FAIL      (fail),
        .A_FAIL_ADDR (fail_addr),
        .A_FAIL_ELEM (fail_elem),
        .A_ERR_CNT   (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] faulty(input logic [13:0] a, input logic [23:0] d);
        logic [23:0] r;
        r = d;
        if (fault_mode == 1 && a == 14'd5)   r[0] = 1'b0;
        if (fault_mode == 2 && a == 14'd255) r[3] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (men && wen) mem[addr] <= din & bm;
        if (men && ren) dout <= faulty(addr, mem[addr]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_test(input bit hold, output int done_at, output int busy_cnt,
                            output int wen_cnt, output int ren_cnt, output int en_bad,
                            output bit first_ok);
        done_at  = -1;
        busy_cnt = 0;
        wen_cnt  = 0;
        ren_cnt  = 0;
        en_bad   = 0;
        first_ok = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                first_ok = busy && men && wen && !ren && (addr == 14'd0) && (din == 24'd0) &&
                           !fail && (err_cnt == 16'd0) && (fail_addr == 14'd0) && (fail_elem == 3'd0);
                if (!hold) start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (men && wen) wen_cnt++;
            if (men && ren) ren_cnt++;
            if (en !== busy) en_bad++;
            if (done) begin
                done_at = n;
                break;
            end
        end
    endtask

    int  done_at, busy_cnt, wen_cnt, ren_cnt, en_bad, done_seen;
    bit  first_ok;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_enables", {29'd0, men, wen, ren}, 32'd0);
        check("rst_addr_din", {addr, din[17:0]}, 32'd0);
        check("rst_results", {fail, fail_elem, fail_addr, err_cnt[13:0]}, 32'd0);
        check("rst_bm", {8'd0, bm}, 32'h00FF_FFFF);
        rst = 1'b0;

        // Fault-free run.
        run_test(1'b0, done_at, busy_cnt, wen_cnt, ren_cnt, en_bad, first_ok);
        check("clean_first_op", {31'd0, first_ok}, 32'd1);
        check("clean_done_at", done_at, 32'd2562);
        check("clean_busy_cnt", busy_cnt, 32'd2561);
        check("clean_writes", wen_cnt, 32'd1280);
        check("clean_reads", ren_cnt, 32'd1280);
        check("clean_en_eq_busy", en_bad, 32'd0);
        check("clean_busy_at_done", {31'd0, busy}, 32'd0);
        check("clean_fail", {31'd0, fail}, 32'd0);
        check("clean_err_cnt", {16'd0, err_cnt}, 32'd0);

        // Address 5 bit 0 stuck at 0.
        fault_mode = 1;
        run_test(1'b0, done_at, busy_cnt, wen_cnt, ren_cnt, en_bad, first_ok);
        check("sa0_done_at", done_at, 32'd2562);
        check("sa0_fail", {31'd0, fail}, 32'd1);
        check("sa0_fail_addr", {18'd0, fail_addr}, 32'd5);
        check("sa0_fail_elem", {29'd0, fail_elem}, 32'd2);
        check("sa0_err_cnt", {16'd0, err_cnt}, 32'd2);
        repeat (5) @(negedge clk);
        check("sa0_hold_done", {31'd0, done}, 32'd0);
        check("sa0_hold_results", {fail, fail_elem, fail_addr, err_cnt[13:0]},
              {1'b1, 3'd2, 14'd5, 14'd2});

        // Address 255 bit 3 stuck at 1; start must clear the previous failure.
        fault_mode = 2;
        run_test(1'b0, done_at, busy_cnt, wen_cnt, ren_cnt, en_bad, first_ok);
        check("sa1_first_op_cleared", {31'd0, first_ok}, 32'd1);
        check("sa1_done_at", done_at, 32'd2562);
        check("sa1_fail", {31'd0, fail}, 32'd1);
        check("sa1_fail_addr", {18'd0, fail_addr}, 32'd255);
        check("sa1_fail_elem", {29'd0, fail_elem}, 32'd1);
        check("sa1_err_cnt", {16'd0, err_cnt}, 32'd3);

        // Repaired memory.
        fault_mode = 0;
        run_test(1'b0, done_at, busy_cnt, wen_cnt, ren_cnt, en_bad, first_ok);
        check("repair_done_at", done_at, 32'd2562);
        check("repair_fail", {31'd0, fail}, 32'd0);
        check("repair_err_cnt", {16'd0, err_cnt}, 32'd0);

        // Reset during M3 (M3 spans cycles 1281..1792 after the start edge).
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1399) @(negedge clk);
        check("m3_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("m3_rst_en", {31'd0, en}, 32'd0);
        check("m3_rst_enables", {28'd0, busy, men, wen, ren}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("m3_abort_no_done", done_seen, 32'd0);
        run_test(1'b0, done_at, busy_cnt, wen_cnt, ren_cnt, en_bad, first_ok);
        check("m3_rerun_done_at", done_at, 32'd2562);
        check("m3_rerun_results", {fail, err_cnt}, 32'd0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("rst_priority_busy", {31'd0, busy}, 32'd0);

        // Start held high: one run, then a new one only after returning to IDLE.
        run_test(1'b1, done_at, busy_cnt, wen_cnt, ren_cnt, en_bad, first_ok);
        check("hold_done_at", done_at, 32'd2562);
        check("hold_busy_cnt", busy_cnt, 32'd2561);
        @(negedge clk);
        check("hold_idle_gap", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        check("hold_restart", {30'd0, busy, men}, 32'd3);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
